md_ctrl: RTL and testbench
==========================

MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for mult/multu (legal range 1-15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for div/divu (legal range 1-15).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port e_valid  in  1  E-stage holds a valid MD-class instruction.
REQ-006 SHALL have port e_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 SHALL have port e_rs  in  32  forwarded rs operand.
REQ-008 SHALL have port e_rt  in  32  forwarded rt operand.
REQ-009 SHALL have port flush  in  1  exception/interrupt/eret kill of the E-stage instruction this cycle.
REQ-010 SHALL have port d_md_use  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port rd_sel  in  1  read select, 0 HI, 1 LO.
REQ-012 SHALL have port rd_data  out  32  selected HI/LO value, combinational.
REQ-013 SHALL have port busy  out  1  multi-cycle operation in progress.
REQ-014 SHALL have port stall_d  out  1  freeze F/D, bubble into E.

Function
REQ-015 SHALL implement FSM with states IDLE and BUSY plus a 4-bit down-counter cnt.
REQ-016 SHALL define start = e_valid && !flush && state==IDLE && e_op in {1,2,3,4}.
REQ-017 On start, SHALL compute the result from e_rs/e_rt into hidden registers res_hi/res_lo, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-018 In BUSY, SHALL decrement cnt each cycle; on the edge where cnt==1, SHALL copy res_hi/res_lo into HI/LO and return to IDLE.
REQ-019 busy SHALL be 1 in exactly N consecutive cycles, N = cycle count of the op, starting the cycle after start; HI/LO SHALL become visible on rd_data in the first cycle with busy==0.
REQ-020 mult: signed 64-bit product, HI = bits 63:32, LO = bits 31:0; multu: same, unsigned.
REQ-021 div: signed, LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned.
REQ-022 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 Divide by zero (e_rt==0) SHALL still run the full DIV_CYCLES, and HI/LO SHALL remain unchanged at completion.
REQ-024 mthi/mtlo with e_valid && !flush in IDLE SHALL write e_rs to HI/LO at that edge, with no busy period.
REQ-025 stall_d SHALL equal d_md_use && (busy || start).
REQ-026 flush SHALL cancel only a same-cycle E-stage op; an operation already in BUSY SHALL complete and commit normally.
REQ-027 e_valid with an MD op while busy==1 is a pipeline protocol error; it SHALL be ignored with no state change.
REQ-028 rd_data SHALL never reflect in-flight res_hi/res_lo.

Reset
REQ-029 While reset==0, SHALL force state=IDLE, cnt=0, HI=0, LO=0, res_hi=0, res_lo=0, so busy=0, stall_d=0, rd_data=0, asynchronously.
REQ-030 Reset asserted mid-BUSY SHALL discard the operation; after release, HI/LO SHALL read 0 and no commit SHALL occur.
REQ-031 The first active edge after reset deassertion SHALL be able to accept a start.

Verification
REQ-032 mult rs=0xFFFFFFFF, rt=2 -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 div rs=-7 (0xFFFFFFF9), rt=2 -> busy exactly 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> HI/LO unchanged after 10 cycles.
REQ-034 mult issued together with flush=1 -> busy stays 0, HI/LO unchanged; flush=1 during cycle 3 of a BUSY div -> commit occurs on schedule.
REQ-035 d_md_use=1 (mflo) in the cycle of start and on each following cycle -> stall_d=1 through the last busy cycle, 0 in the next cycle, with rd_sel=1 giving the new LO.
REQ-036 mtlo rs=0x12345678 -> LO=0x12345678 next cycle with busy=0; reset pulse low in cycle 4 of a mult -> busy=0 immediately, HI=LO=0 after release.

Source files
------------

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO multiply/divide unit with busy/stall control for a 5-stage pipeline
//
// Purpose: accepts mult/multu/div/divu from the E stage, computes the result at
// issue into hidden registers, holds busy for a fixed number of cycles and
// then commits to the architectural HI/LO. mthi/mtlo write HI/LO directly.
//
// Ports:
//   clk       - sole clock, rising edge
//   reset     - asynchronous active-low reset
//   e_valid   - E stage holds a valid MD-class instruction
//   e_op      - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   e_rs/e_rt - forwarded operands
//   flush     - kill of the E-stage instruction this cycle
//   d_md_use  - D-stage instruction touches the MD unit
//   rd_sel    - 0 reads HI, 1 reads LO
//   rd_data   - architectural HI or LO (combinational)
//   busy      - multi-cycle operation in progress
//   stall_d   - freeze F/D and bubble into E

module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        d_md_use,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        stall_d
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] res_hi_q;
    logic [31:0] res_lo_q;
    // Cleared for divide-by-zero so the busy period runs but HI/LO are kept.
    logic        commit_q;

    logic        is_arith;
    logic        is_mult;
    logic        accept;
    logic        start;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [32:0] div_a;
    logic signed [32:0] div_b;
    logic signed [32:0] quot_s;
    logic signed [32:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic        [31:0] res_hi_d;
    logic        [31:0] res_lo_d;
    logic               unused_div_msb;

    assign is_arith = (e_op == OP_MULT) || (e_op == OP_MULTU) ||
                      (e_op == OP_DIV)  || (e_op == OP_DIVU);
    assign is_mult  = (e_op == OP_MULT) || (e_op == OP_MULTU);

    // Gated by reset so stall_d is forced low while reset is held.
    assign accept = reset && e_valid && !flush && (state_q == IDLE);
    assign start  = accept && is_arith;

    assign busy    = (state_q == BUSY);
    assign stall_d = d_md_use && (busy || start);
    assign rd_data = rd_sel ? lo_q : hi_q;

    assign prod_s = $signed({{32{e_rs[31]}}, e_rs}) * $signed({{32{e_rt[31]}}, e_rt});
    assign prod_u = {32'b0, e_rs} * {32'b0, e_rt};

    // 33-bit signed divide so 0x80000000 / -1 yields +2^31 without overflow;
    // its low word is the required 0x80000000 with remainder 0.
    assign div_a  = $signed({e_rs[31], e_rs});
    assign div_b  = $signed({e_rt[31], e_rt});
    assign quot_s = (e_rt == 32'd0) ? 33'sd0 : div_a / div_b;
    assign rem_s  = (e_rt == 32'd0) ? 33'sd0 : div_a % div_b;
    assign quot_u = (e_rt == 32'd0) ? 32'd0 : e_rs / e_rt;
    assign rem_u  = (e_rt == 32'd0) ? 32'd0 : e_rs % e_rt;
    assign unused_div_msb = quot_s[32] ^ rem_s[32];

    always_comb begin
        res_hi_d = 32'd0;
        res_lo_d = 32'd0;
        case (e_op)
            OP_MULT: begin
                res_hi_d = prod_s[63:32];
                res_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
                res_hi_d = prod_u[63:32];
                res_lo_d = prod_u[31:0];
            end
            OP_DIV: begin
                res_hi_d = rem_s[31:0];
                res_lo_d = quot_s[31:0];
            end
            OP_DIVU: begin
                res_hi_d = rem_u;
                res_lo_d = quot_u;
            end
            default: begin
                res_hi_d = 32'd0;
                res_lo_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            commit_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= BUSY;
                        cnt_q    <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        res_hi_q <= res_hi_d;
                        res_lo_q <= res_lo_d;
                        commit_q <= is_mult || (e_rt != 32'd0);
                    end else if (accept && (e_op == OP_MTHI)) begin
                        hi_q <= e_rs;
                    end else if (accept && (e_op == OP_MTLO)) begin
                        lo_q <= e_rs;
                    end
                end
                BUSY: begin
                    // E-stage requests are ignored here; flush only affects issue.
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= IDLE;
                        if (commit_q) begin
                            hi_q <= res_hi_q;
                            lo_q <= res_lo_q;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - randomized self-checking bench for md_ctrl against an arithmetic reference model

module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        flush;
    logic        d_md_use;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall_d;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural HI/LO, pending result, cycles left.
    logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
    logic        m_commit;
    int          m_left;

    logic        obs_busy, obs_stall;
    logic [31:0] obs_rd;

    md_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk      (clk),
        .reset    (reset),
        .e_valid  (e_valid),
        .e_op     (e_op),
        .e_rs     (e_rs),
        .e_rt     (e_rt),
        .flush    (flush),
        .d_md_use (d_md_use),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .busy     (busy),
        .stall_d  (stall_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic v, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic fl);
        longint      sp, sa, sb, q, r;
        logic [63:0] w, wq, wr;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_rhi;
                m_lo = m_rlo;
            end
        end else if (v && !fl) begin
            case (op)
                3'd1: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    w = sp;
                    m_rhi = w[63:32]; m_rlo = w[31:0]; m_commit = 1'b1; m_left = MULT_N;
                end
                3'd2: begin
                    w = {32'b0, a} * {32'b0, b};
                    m_rhi = w[63:32]; m_rlo = w[31:0]; m_commit = 1'b1; m_left = MULT_N;
                end
                3'd3, 3'd4: begin
                    m_left = DIV_N;
                    m_commit = (b != 32'd0);
                    if (b != 32'd0) begin
                        if (op == 3'd3) begin
                            sa = longint'($signed(a));
                            sb = longint'($signed(b));
                        end else begin
                            sa = longint'({32'b0, a});
                            sb = longint'({32'b0, b});
                        end
                        q = sa / sb;
                        r = sa - q * sb;
                        wq = q;
                        wr = r;
                        m_rlo = wq[31:0];
                        m_rhi = wr[31:0];
                    end
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, advance model.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic fl, input logic dmd, input logic rs);
        logic st;
        e_valid = v; e_op = op; e_rs = a; e_rt = b; flush = fl; d_md_use = dmd; rd_sel = rs;
        @(negedge clk);
        st = v && !fl && (m_left == 0) && (op >= 3'd1) && (op <= 3'd4);
        obs_busy = busy; obs_stall = stall_d; obs_rd = rd_data;
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("stall_d", 32'(stall_d), 32'(dmd && ((m_left > 0) || st)));
        chk("rd_data", rd_data, rs ? m_lo : m_hi);
        model_update(v, op, a, b, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fl, input logic dmd, input logic rs);
        step(1'b0, 3'd0, 32'd0, 32'd0, fl, dmd, rs);
    endtask

    // Issue an op with d_md_use held, measure the busy window, check the commit.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] ehi,
                          input logic [31:0] elo, input int fl_cyc);
        int cnt = 0;
        bit done = 0;
        step(1'b1, op, a, b, 1'b0, 1'b1, 1'b1);
        chk({tag, "_stall_at_start"}, 32'(obs_stall), 32'd1);
        for (int i = 0; i < 40 && !done; i++) begin
            idle(cnt + 1 == fl_cyc, 1'b1, 1'b1);
            if (obs_busy) cnt++;
            else begin
                done = 1;
                chk({tag, "_stall_after"}, 32'(obs_stall), 32'd0);
                chk({tag, "_lo"}, obs_rd, elo);
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_len"}, 32'(cnt), 32'(n));
        idle(1'b0, 1'b0, 1'b0);
        chk({tag, "_hi"}, obs_rd, ehi);
    endtask

    task automatic do_reset();
        e_valid = 1'b1; e_op = 3'd1; e_rs = 32'd3; e_rt = 32'd5; flush = 1'b0; d_md_use = 1'b1;
        rd_sel = 1'b0;
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_d), 32'd0);
        chk("rst_hi", rd_data, 32'd0);
        rd_sel = 1'b1;
        #1;
        chk("rst_lo", rd_data, 32'd0);
        m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_commit = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_release_lo", rd_data, 32'd0);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 10));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        m_hi = 32'd0; m_lo = 32'd0; m_rhi = 32'd0; m_rlo = 32'd0; m_commit = 1'b0; m_left = 0;
        reset = 1'b0;
        e_valid = 1'b0; e_op = 3'd0; e_rs = 32'd0; e_rt = 32'd0;
        flush = 1'b0; d_md_use = 1'b0; rd_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_op("mult",      3'd1, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("multu",     3'd2, 32'hFFFF_FFFF, 32'd2, MULT_N, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        run_op("div",       3'd3, 32'hFFFF_FFF9, 32'd2, DIV_N,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'd0, 32'h8000_0000, 0);
        run_op("divu_zero", 3'd4, 32'd7, 32'd0, DIV_N, 32'd0, 32'h8000_0000, 0);
        run_op("div_flush", 3'd3, 32'd9, 32'd4, DIV_N, 32'd1, 32'd2, 3);

        // mult killed by flush in its issue cycle
        step(1'b1, 3'd1, 32'd7, 32'd7, 1'b1, 1'b1, 1'b0);
        idle(1'b0, 1'b0, 1'b0);
        chk("flush_no_busy", 32'(obs_busy), 32'd0);
        chk("flush_hi_kept", obs_rd, 32'd1);

        step(1'b1, 3'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0, 1'b1);
        chk("mtlo_lo", obs_rd, 32'h1234_5678);
        chk("mtlo_no_busy", 32'(obs_busy), 32'd0);

        // reset during busy cycle 4 of a mult, then a start on the first edge
        step(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        repeat (3) idle(1'b0, 1'b0, 1'b0);
        do_reset();
        run_op("mult_after_rst", 3'd1, 32'd3, 32'd5, MULT_N, 32'd0, 32'd15, 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), rnd_word(), rnd_word(),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        repeat (DIV_N + 1) idle(1'b0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
